// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO write side.
//   PTR_WIDTH_DEF  : default address width (depth = 2**PTR_WIDTH_DEF)
//   DATA_WIDTH_DEF : default word width
//   NUM_REQ_DEF    : default number of write requesters
//   rr_idx_t       : round-robin index type for the default requester count
//   bin2gray       : binary to reflected Gray code conversion
package fifo_pkg;

  localparam int PTR_WIDTH_DEF  = 9;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int NUM_REQ_DEF    = 4;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] rr_idx_t;

  // Callers size-cast the result down to their own pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin arbiter for the FIFO write port.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset (rr pointer -> 0)
//   req_i       : per-requester request levels
//   en_i        : grant enable (low when the FIFO is full or in reset)
//   gnt_o       : one-hot grant, combinational
//   grant_any_o : any grant this cycle
//   grant_idx_o : index of the granted requester
module rr_arbiter #(
  parameter int num_req = 4,
  localparam int IDX_W = $clog2(num_req)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [num_req-1:0] req_i,
  input  logic               en_i,
  output logic [num_req-1:0] gnt_o,
  output logic               grant_any_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  logic [IDX_W-1:0] rr_q, rr_d;
  logic [IDX_W-1:0] kidx;
  int               k;

  // Scan starting at rr_q, wrapping; the first active request wins.
  always_comb begin
    gnt_o       = '0;
    grant_any_o = 1'b0;
    grant_idx_o = '0;
    k           = 0;
    kidx        = '0;
    for (int i = 0; i < num_req; i++) begin
      k    = (int'(rr_q) + i) % num_req;
      kidx = IDX_W'(k);
      if (en_i && !grant_any_o && req_i[kidx]) begin
        gnt_o[kidx] = 1'b1;
        grant_any_o = 1'b1;
        grant_idx_o = kidx;
      end
    end
  end

  // The winner drops to lowest priority; without a grant the pointer holds.
  always_comb begin
    rr_d = rr_q;
    if (grant_any_o) begin
      if (grant_idx_o == IDX_W'(num_req - 1)) rr_d = '0;
      else                                    rr_d = grant_idx_o + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO (write clock domain).
// Arbitrates the single RAM write port among num_req requesters, owns the
// binary/Gray write pointers and computes the registered full flag.
//   wclk      : write clock
//   w_rst     : synchronous active-high reset
//   req       : per-requester write request (held until granted)
//   req_data  : requester i's word at [i*data_width +: data_width]
//   gnt       : one-hot accept, combinational
//   rptr_sync : Gray read pointer already synchronised into wclk
//   winc      : RAM write strobe
//   waddr     : RAM write address
//   wdata     : RAM write data
//   wptr      : Gray write pointer for the write-to-read synchroniser
//   wfull     : FIFO full
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int ptr_width  = PTR_WIDTH_DEF,
  parameter int data_width = DATA_WIDTH_DEF,
  parameter int num_req    = NUM_REQ_DEF,
  localparam int PW1   = ptr_width + 1,
  localparam int IDX_W = $clog2(num_req)
) (
  input  logic                          wclk,
  input  logic                          w_rst,
  input  logic [num_req-1:0]            req,
  input  logic [num_req*data_width-1:0] req_data,
  output logic [num_req-1:0]            gnt,
  input  logic [PW1-1:0]                rptr_sync,
  output logic                          winc,
  output logic [ptr_width-1:0]          waddr,
  output logic [data_width-1:0]         wdata,
  output logic [PW1-1:0]                wptr,
  output logic                          wfull
);

  logic                  grant_any;
  logic [IDX_W-1:0]      grant_idx;
  logic [data_width-1:0] word_sel;

  logic [PW1-1:0]        wbin_q, wbin_d;
  logic [PW1-1:0]        wgray_next;
  logic                  wfull_q, wfull_d;
  logic [PW1-1:0]        wptr_q;
  logic                  winc_q;
  logic [ptr_width-1:0]  waddr_q;
  logic [data_width-1:0] wdata_q;

  // Grants are suppressed while full and while reset is asserted.
  rr_arbiter #(.num_req(num_req)) u_rr (
    .clk_i       (wclk),
    .rst_i       (w_rst),
    .req_i       (req),
    .en_i        (!wfull_q && !w_rst),
    .gnt_o       (gnt),
    .grant_any_o (grant_any),
    .grant_idx_o (grant_idx)
  );

  assign word_sel = req_data[int'(grant_idx)*data_width +: data_width];

  // Full when the next write pointer equals the read pointer with its two
  // MSBs inverted (one full lap ahead). Using the post-grant pointer makes
  // wfull rise on the same edge as the write that fills the last slot.
  assign wbin_d     = wbin_q + PW1'(grant_any);
  assign wgray_next = PW1'(bin2gray(32'(wbin_d)));
  assign wfull_d    = (wgray_next ==
                       {~rptr_sync[ptr_width:ptr_width-1], rptr_sync[ptr_width-2:0]});

  // Grant cycle -> RAM write strobe, address and data one edge later.
  always_ff @(posedge wclk) begin
    if (w_rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
      winc_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_next;
      wfull_q <= wfull_d;
      winc_q  <= grant_any;
      if (grant_any) begin
        waddr_q <= wbin_q[ptr_width-1:0];
        wdata_q <= word_sel;
      end
    end
  end

  assign winc  = winc_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign wptr  = wptr_q;
  assign wfull = wfull_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        wclk;
  logic        w_rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  rptr_sync;
  logic        winc;
  logic [2:0]  waddr;
  logic [7:0]  wdata;
  logic [3:0]  wptr;
  logic        wfull;

  fifo_wr_arbiter #(.ptr_width(3), .data_width(8), .num_req(4)) dut (
    .wclk      (wclk),
    .w_rst     (w_rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .rptr_sync (rptr_sync),
    .winc      (winc),
    .waddr     (waddr),
    .wdata     (wdata),
    .wptr      (wptr),
    .wfull     (wfull)
  );

  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
    logic [3:0] p;
    logic       f;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Bench model state: binary write pointer and full flag after the last edge.
  logic [3:0] m_wbin = 4'd0;
  logic       m_full = 1'b0;

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after an edge, check the combinational grant,
  // queue the expected RAM write (if any), then advance one edge.
  task automatic step(input logic rst, input logic [3:0] rq, input logic [31:0] dat,
                      input logic [3:0] rp, input logic [3:0] exp_gnt, input string name);
    logic       inc;
    logic [3:0] nxt;
    logic       nfull;
    logic [7:0] word;
    w_rst = rst; req = rq; req_data = dat; rptr_sync = rp;
    #2;
    chk({name, " gnt"}, 32'(gnt), 32'(exp_gnt));
    inc  = 1'b0;
    word = 8'h00;
    if (rst) begin
      m_wbin = 4'd0;
      m_full = 1'b0;
    end else begin
      inc   = (exp_gnt != 4'd0);
      nxt   = m_wbin + 4'(inc);
      nfull = (g(nxt) == {~rp[3:2], rp[1:0]});
      for (int i = 0; i < 4; i++)
        if (exp_gnt[i]) word = dat[i*8 +: 8];
      if (inc) sb.push_back('{a: m_wbin[2:0], d: word, p: g(nxt), f: nfull});
      m_wbin = nxt;
      m_full = nfull;
    end
    @(posedge wclk); #1;
    if (!inc) begin
      chk({name, " idle winc"}, 32'(winc), 32'(0));
      chk({name, " idle wptr"}, 32'(wptr), 32'(g(m_wbin)));
      chk({name, " idle wfull"}, 32'(wfull), 32'(m_full));
    end
  endtask

  // Monitor: every RAM write presented by the DUT is matched against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      if (winc === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected write: waddr %0h wdata %0h, expected no write", waddr, wdata);
        end else begin
          e = sb.pop_front();
          chk("write waddr", 32'(waddr), 32'(e.a));
          chk("write wdata", 32'(wdata), 32'(e.d));
          chk("write wptr",  32'(wptr),  32'(e.p));
          chk("write wfull", 32'(wfull), 32'(e.f));
        end
      end
    end
  end

  logic [3:0] lag;

  initial begin
    w_rst = 1'b1; req = 4'b1111; req_data = 32'h0; rptr_sync = 4'h0;
    @(posedge wclk); #1;

    // Reset with all requests pending.
    step(1'b1, 4'b1111, 32'h0, 4'h0, 4'b0000, "reset");
    step(1'b1, 4'b1111, 32'h0, 4'h0, 4'b0000, "reset");
    chk("reset waddr", 32'(waddr), 32'(0));

    // Single request.
    step(1'b0, 4'b0001, 32'h000000A5, 4'h0, 4'b0001, "single");
    step(1'b0, 4'b0000, 32'h000000A5, 4'h0, 4'b0000, "single idle");

    // Contention from a fresh reset, read pointer tracking the write pointer.
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset3");
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset3");
    step(1'b0, 4'b1111, 32'h13121110, g(m_wbin), 4'b0001, "contend");
    step(1'b0, 4'b1111, 32'h13121110, g(m_wbin), 4'b0010, "contend");
    step(1'b0, 4'b1111, 32'h13121110, g(m_wbin), 4'b0100, "contend");
    step(1'b0, 4'b1111, 32'h13121110, g(m_wbin), 4'b1000, "contend");
    step(1'b0, 4'b1111, 32'h13121110, g(m_wbin), 4'b0001, "contend");

    // Fill with the read pointer parked at 0.
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset4");
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset4");
    for (int n = 0; n < 8; n++)
      step(1'b0, 4'b0001, 32'(8'hC0 + n), 4'h0, 4'b0001, "fill");
    step(1'b0, 4'b0001, 32'h000000C8, 4'h0, 4'b0000, "full blocked");
    chk("full wfull", 32'(wfull), 32'(1));
    chk("full wptr",  32'(wptr),  32'(4'b1100));
    step(1'b0, 4'b0001, 32'h000000C8, 4'b0001, 4'b0000, "rptr advance");
    chk("unfull wfull", 32'(wfull), 32'(0));
    step(1'b0, 4'b0001, 32'h000000C8, 4'b0001, 4'b0001, "resume");

    // Wrap-around: 16 writes with the read pointer two words behind.
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset5");
    step(1'b1, 4'b0000, 32'h0, 4'h0, 4'b0000, "reset5");
    for (int n = 0; n < 16; n++) begin
      lag = (m_wbin >= 4'd2) ? m_wbin - 4'd2 : 4'd0;
      step(1'b0, 4'b1111, 32'hE3E2E1E0, g(lag), 4'(1 << (n % 4)), "wrap");
    end
    chk("wrap wptr",  32'(wptr),  32'(4'b0000));
    chk("wrap wfull", 32'(wfull), 32'(0));

    // Reset in the middle of a burst.
    step(1'b0, 4'b1111, 32'hE3E2E1E0, g(m_wbin - 4'd2), 4'b0001, "burst");
    step(1'b0, 4'b1111, 32'hE3E2E1E0, g(m_wbin - 4'd2), 4'b0010, "burst");
    step(1'b1, 4'b1111, 32'hE3E2E1E0, 4'h0, 4'b0000, "mid reset");
    step(1'b0, 4'b1111, 32'hE3E2E1E0, 4'h0, 4'b0001, "after reset");

    step(1'b0, 4'b0000, 32'h0, 4'h0, 4'b0000, "drain");
    step(1'b0, 4'b0000, 32'h0, 4'h0, 4'b0000, "drain");
    chk("scoreboard empty", 32'(sb.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
